mdio_master_param: RTL and testbench
====================================

Name: mdio_master_param

Overview:
Parametrised MDIO management master (station management entity) that serialises one management frame per request onto MDC/MDIO. It generalises the fixed controller used with the MDIO peripheral bench: the MDC divider and preamble length are configurable, and the block supports both Clause 22 and Clause 45 framing. It sits between the register-access logic and the pad-level MDIO tristate. The tristate itself is outside the block, driven by mdio_out/mdio_oe.

Parameters:
CLK_DIV, 4, MDC half-period in clk cycles (>=1); MDC period = 2*CLK_DIV clk cycles
PREAMBLE_LEN, 32, number of preamble '1' bits (0 = preamble suppression)
C45_EN, 1, 1 = Clause 45 framing accepted; 0 = any request with req_c45=1 is rejected

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
req_start  input  1  request strobe, sampled every clk
req_c45  input  1  0 = Clause 22 frame, 1 = Clause 45 frame
req_op  input  2  OP field; C22: 01 write, 10 read; C45: 00 address, 01 write, 11 read, 10 read-post-increment
req_phy  input  5  PHYAD (C22) / PRTAD (C45)
req_reg  input  5  REGAD (C22) / DEVAD (C45)
req_wdata  input  16  write data or C45 address
rdata  output  16  read data, valid when done=1 for read ops; holds until next read completes
busy  output  1  frame in progress
done  output  1  one-cycle pulse at frame end
err  output  1  one-cycle pulse when a request is rejected
mdc  output  1  management clock
mdio_out  output  1  serial data to pad
mdio_oe  output  1  pad output enable
mdio_in  input  1  serial data from pad

Behaviour:
- Reset values: rdata=0, busy=0, done=0, err=0, mdc=0, mdio_out=1, mdio_oe=0; FSM to IDLE. Reset asserted mid-frame aborts the frame on the next edge; no done is generated.
- States: IDLE -> PRE (PREAMBLE_LEN bits; skipped if 0) -> HDR (ST 2, OP 2, PHY 5, REG 5 = 14 bits) -> TA (2 bits) -> DATA (16 bits) -> IDLE.
- ST field: 01 for C22, 00 for C45. All fields are sent MSB first.
- Request acceptance: only in IDLE with busy=0. req_* is latched on the accepting edge, and busy=1 from the next cycle.
  - req_start while busy: ignored. No err pulse; latched fields unchanged.
- Rejection: C22 with op 00/11, or req_c45=1 with C45_EN=0.
  - err pulses 1 cycle after the request; busy stays 0.
- Bit timing: each bit starts with mdc=0, with mdio_out updated in that same cycle.
  - After CLK_DIV cycles mdc rises; after CLK_DIV more cycles the next bit starts.
  - Bit clock is a down-counter reloaded to CLK_DIV-1.
- Read ops (C22 10, C45 11/10):
  - mdio_oe=0 from the first TA bit to frame end.
  - mdio_in is sampled in the cycle mdc rises, for each of the 16 DATA bits, and shifted in MSB first.
- Write/address ops:
  - mdio_oe=1 for the whole frame.
  - TA driven 1,0; DATA = req_wdata.
- Frame end: after the high phase of the last DATA bit, mdc returns 0, busy=0 and done=1 in the same cycle.
  - rdata is updated in that cycle (read ops only).
  - mdio_out=1 and mdio_oe=0 on return to IDLE.
  - A new req_start in that done cycle is accepted.
- Frame length: (PREAMBLE_LEN+32) bits × 2*CLK_DIV clk cycles from the first busy cycle to done.
- mdc is held 0 while idle; no free-running MDC.

Test Plan:
- CLK_DIV=2, PREAMBLE_LEN=32, C22 write phy=5 reg=3 wdata=0xA5C3 -> mdio_out at mdc rising edges = 32×'1', 01 01 00101 00011 10 1010010111000011; mdio_oe=1 throughout; done exactly 256 clk after busy rises.
- C22 read phy=1 reg=2, bench peripheral drives 0x1234 after TA -> mdio_oe=0 from TA bit 1; done pulse with rdata=0x1234; write bits before TA match 01 10 00001 00010.
- C45 address op prtad=3 devad=1 wdata=0x0010, then C45 read (op 11) returning 0xBEEF -> ST=00 on both frames; rdata=0xBEEF; two done pulses, one per frame.
- req_start held high during a frame, plus a second request with different fields mid-frame -> ignored; the frame bits still match the first request; the next request is accepted only at/after done.
- Reset asserted at bit 40 of a write, then a C22 op=11 request and (C45_EN=0 build) a C45 request -> after reset: mdc=0, mdio_oe=0, busy=0, no done; each illegal request gives a single err pulse and busy stays 0.
- PREAMBLE_LEN=0, CLK_DIV=1 read -> first mdc-rising bit is ST '0'; done after 64 clk.

Source files
------------

// File: rtl/mdio_master_param.sv
// rtl/mdio_master_param.sv - parametrised MDIO management master (Clause 22 / Clause 45)
//
// Serialises one management frame per accepted request onto mdc/mdio_out/mdio_oe.
// Frame: PREAMBLE_LEN ones, ST(2) OP(2) PHY(5) REG(5), TA(2), DATA(16), all MSB first.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   req_start           request strobe (accepted only when idle)
//   req_c45, req_op     framing select and OP field
//   req_phy, req_reg    PHYAD/PRTAD and REGAD/DEVAD
//   req_wdata           write data or Clause 45 address
//   rdata               last completed read data
//   busy, done, err     frame in progress, end-of-frame pulse, rejected-request pulse
//   mdc, mdio_out       management clock and serial data to pad
//   mdio_oe, mdio_in    pad output enable and serial data from pad
module mdio_master_param #(
  parameter int CLK_DIV      = 4,
  parameter int PREAMBLE_LEN = 32,
  parameter bit C45_EN       = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_start,
  input  logic        req_c45,
  input  logic [1:0]  req_op,
  input  logic [4:0]  req_phy,
  input  logic [4:0]  req_reg,
  input  logic [15:0] req_wdata,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oe,
  input  logic        mdio_in
);

  localparam int CNT_MAX = (PREAMBLE_LEN > 16) ? PREAMBLE_LEN : 16;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'((PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DATA} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;     // bits left in current state, minus one
  logic [DIV_W-1:0]  div_q, div_d;     // half-period down-counter
  logic [31:0]       sh_q, sh_d;       // header/TA/data bits, current bit at [31]
  logic [15:0]       rx_q, rx_d;
  logic              rd_q, rd_d;
  logic              mdc_q, mdc_d;
  logic              mdio_out_q, mdio_out_d;
  logic              mdio_oe_q, mdio_oe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [15:0]       rdata_q, rdata_d;

  logic        active, tick, rise, adv, last, sample, legal, accept, reject;
  logic [15:0] rx_next;
  logic [31:0] frame;

  assign active  = (state_q != S_IDLE);
  assign tick    = (div_q == '0);
  assign rise    = active && !mdc_q && tick;
  assign adv     = active && mdc_q && tick;
  assign last    = (state_q == S_DATA) && (cnt_q == '0);
  // Read data is captured at the end of the first high-phase cycle of each DATA bit.
  assign sample  = (state_q == S_DATA) && rd_q && mdc_q && (div_q == DIV_MAX);
  assign rx_next = sample ? {rx_q[14:0], mdio_in} : rx_q;
  assign legal   = req_c45 ? C45_EN : (req_op == 2'b01 || req_op == 2'b10);
  assign accept  = !active && !busy_q && req_start && legal;
  assign reject  = !active && !busy_q && req_start && !legal;
  // Legal reads always have OP[1]=1; their TA/DATA slots are not driven, so fill with ones.
  assign frame   = {req_c45 ? 2'b00 : 2'b01, req_op, req_phy, req_reg,
                    req_op[1] ? 18'h3FFFF : {2'b10, req_wdata}};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      sh_q       <= '0;
      rx_q       <= '0;
      rd_q       <= 1'b0;
      mdc_q      <= 1'b0;
      mdio_out_q <= 1'b1;
      mdio_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      sh_q       <= sh_d;
      rx_q       <= rx_d;
      rd_q       <= rd_d;
      mdc_q      <= mdc_d;
      mdio_out_q <= mdio_out_d;
      mdio_oe_q  <= mdio_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    sh_d    = sh_q;
    rd_d    = rd_q;
    rx_d    = rx_next;
    if (!active) begin
      if (accept) begin
        sh_d  = frame;
        rd_d  = req_op[1];
        div_d = DIV_MAX;
        if (PREAMBLE_LEN > 0) begin
          state_d = S_PRE;
          cnt_d   = PRE_LAST;
        end else begin
          state_d = S_HDR;
          cnt_d   = CNT_W'(13);
        end
      end
    end else begin
      div_d = tick ? DIV_MAX : div_q - 1'b1;
      if (adv) begin
        if (state_q != S_PRE) sh_d = {sh_q[30:0], 1'b1};
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          case (state_q)
            S_PRE:   begin state_d = S_HDR;  cnt_d = CNT_W'(13); end
            S_HDR:   begin state_d = S_TA;   cnt_d = CNT_W'(1);  end
            S_TA:    begin state_d = S_DATA; cnt_d = CNT_W'(15); end
            default: begin state_d = S_IDLE; cnt_d = '0;         end
          endcase
        end
      end
    end
  end

  always_comb begin
    mdc_d      = mdc_q;
    mdio_out_d = mdio_out_q;
    mdio_oe_d  = mdio_oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    rdata_d    = rdata_q;
    if (!active) begin
      mdc_d      = 1'b0;
      mdio_out_d = 1'b1;
      mdio_oe_d  = 1'b0;
      busy_d     = 1'b0;
      if (accept) begin
        busy_d     = 1'b1;
        mdio_oe_d  = 1'b1;
        mdio_out_d = (PREAMBLE_LEN > 0) ? 1'b1 : frame[31];
      end
      if (reject) err_d = 1'b1;
    end else if (rise) begin
      mdc_d = 1'b1;
    end else if (adv) begin
      mdc_d = 1'b0;
      if (last) begin
        busy_d     = 1'b0;
        done_d     = 1'b1;
        mdio_out_d = 1'b1;
        mdio_oe_d  = 1'b0;
        if (rd_q) rdata_d = rx_next;
      end else begin
        // Leaving the preamble the next bit is still at [31]; otherwise it is the one about to shift up.
        mdio_out_d = (state_d == S_PRE) ? 1'b1 : ((state_q == S_PRE) ? sh_q[31] : sh_q[30]);
        mdio_oe_d  = !(rd_q && (state_d == S_TA || state_d == S_DATA));
      end
    end
  end

  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign mdc      = mdc_q;
  assign mdio_out = mdio_out_q;
  assign mdio_oe  = mdio_oe_q;

endmodule

// File: tb/tb_mdio_master_param.sv
// tb/tb_mdio_master_param.sv - self-checking bench for mdio_master_param
module tb_mdio_master_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start0, start1, req_c45, mdio_in, sel;
  logic [1:0]  req_op;
  logic [4:0]  req_phy, req_reg;
  logic [15:0] req_wdata;
  logic [15:0] rdata0, rdata1, rdata_s;
  logic busy0, done0, err0, mdc0, mout0, moe0;
  logic busy1, done1, err1, mdc1, mout1, moe1;
  logic busy_s, done_s, err_s, mdc_s, mout_s, moe_s;

  int checks = 0;
  int errors = 0;

  mdio_master_param #(.CLK_DIV(2), .PREAMBLE_LEN(32), .C45_EN(1'b1)) u0 (
    .clk(clk), .reset(reset), .req_start(start0), .req_c45(req_c45), .req_op(req_op),
    .req_phy(req_phy), .req_reg(req_reg), .req_wdata(req_wdata), .rdata(rdata0),
    .busy(busy0), .done(done0), .err(err0), .mdc(mdc0), .mdio_out(mout0),
    .mdio_oe(moe0), .mdio_in(mdio_in));

  mdio_master_param #(.CLK_DIV(1), .PREAMBLE_LEN(0), .C45_EN(1'b0)) u1 (
    .clk(clk), .reset(reset), .req_start(start1), .req_c45(req_c45), .req_op(req_op),
    .req_phy(req_phy), .req_reg(req_reg), .req_wdata(req_wdata), .rdata(rdata1),
    .busy(busy1), .done(done1), .err(err1), .mdc(mdc1), .mdio_out(mout1),
    .mdio_oe(moe1), .mdio_in(mdio_in));

  always_comb begin
    if (sel) begin
      rdata_s = rdata1; busy_s = busy1; done_s = done1; err_s = err1;
      mdc_s = mdc1; mout_s = mout1; moe_s = moe1;
    end else begin
      rdata_s = rdata0; busy_s = busy0; done_s = done0; err_s = err0;
      mdc_s = mdc0; mout_s = mout0; moe_s = moe0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected serial stream: preamble ones, then the 32 frame bits; mask marks bits the master drives.
  task automatic model(input bit rd, input int pre, input logic [31:0] fr,
                       output logic [63:0] exp, output logic [63:0] mask);
    logic [31:0] f;
    f = fr;
    exp = '0;
    mask = '0;
    for (int i = 0; i < pre + 32; i++) begin
      if (i < pre) begin
        exp = {exp[62:0], 1'b1};
      end else begin
        exp = {exp[62:0], f[31]};
        f = {f[30:0], 1'b0};
      end
      mask = {mask[62:0], (!rd || i < pre + 14) ? 1'b1 : 1'b0};
    end
  endtask

  task automatic set_start(input bit inst, input logic v);
    if (inst) start1 = v; else start0 = v;
  endtask

  task automatic run_frame(input bit inst, input bit c45, input logic [1:0] op,
                           input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] wd,
                           input logic [15:0] rword, input logic [15:0] exp_rdata,
                           input bit hold, input bit mid);
    int pre, div, t, rises, falls, gap;
    bit prev, rd, got_done;
    logic [63:0] got, goe, exp, mask;
    logic [15:0] rsh;
    pre = inst ? 0 : 32;
    div = inst ? 1 : 2;
    rd = op[1];
    sel = inst;
    model(rd, pre, {c45 ? 2'b00 : 2'b01, op, phy, rg, 2'b10, wd}, exp, mask);
    got = '0; goe = '0; rises = 0; falls = 0; gap = 0; prev = 1'b0; got_done = 1'b0;
    rsh = rword;
    @(negedge clk);
    req_c45 = c45; req_op = op; req_phy = phy; req_reg = rg; req_wdata = wd;
    mdio_in = 1'b1;
    set_start(inst, 1'b1);
    for (t = 1; t <= 2000; t++) begin
      @(negedge clk);
      if (mdc_s && !prev) begin
        got = {got[62:0], mout_s};
        goe = {goe[62:0], moe_s};
        rises++;
      end
      if (!mdc_s && prev) begin
        falls++;
        if (falls > pre + 16 && falls < pre + 32) rsh = {rsh[14:0], 1'b0};
      end
      prev = mdc_s;
      mdio_in = (rd && falls >= pre + 16 && falls < pre + 32) ? rsh[15] : 1'b1;
      if (t == 1) begin
        chk("busy_after_accept", 64'(busy_s), 64'(1));
        if (!hold) set_start(inst, 1'b0);
      end
      if (mid && t == 50) begin
        req_c45 = ~c45; req_op = ~op; req_phy = ~phy; req_reg = ~rg; req_wdata = ~wd;
        set_start(inst, 1'b1);
      end
      if (mid && !hold && t == 51) set_start(inst, 1'b0);
      if (done_s) begin
        got_done = 1'b1;
        break;
      end
      if (!busy_s) gap++;
    end
    chk("done_seen", 64'(got_done), 64'(1));
    if (got_done) begin
      chk("frame_len", 64'(t - 1), 64'((pre + 32) * 2 * div));
      chk("done_busy", 64'(busy_s), 64'(0));
      chk("done_mdc", 64'(mdc_s), 64'(0));
      chk("done_oe", 64'(moe_s), 64'(0));
      chk("done_mdio", 64'(mout_s), 64'(1));
      chk("rdata", 64'(rdata_s), 64'(exp_rdata));
      chk("bit_count", 64'(rises), 64'(pre + 32));
      chk("bits", got & mask, exp & mask);
      chk("oe_stream", goe, mask);
      chk("busy_gap", 64'(gap), 64'(0));
    end
    @(negedge clk);
    chk("done_pulse_width", 64'(done_s), 64'(0));
    chk("busy_after_done", 64'(busy_s), 64'(hold ? 1 : 0));
    start0 = 1'b0;
    start1 = 1'b0;
    mdio_in = 1'b1;
  endtask

  task automatic run_reject(input bit inst, input bit c45, input logic [1:0] op,
                            input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] wd,
                            input logic [15:0] exp_rdata);
    sel = inst;
    @(negedge clk);
    req_c45 = c45; req_op = op; req_phy = phy; req_reg = rg; req_wdata = wd;
    set_start(inst, 1'b1);
    @(negedge clk);
    set_start(inst, 1'b0);
    chk("err_pulse", 64'(err_s), 64'(1));
    chk("reject_busy", 64'(busy_s), 64'(0));
    @(negedge clk);
    chk("err_single", 64'(err_s), 64'(0));
    chk("reject_busy2", 64'(busy_s), 64'(0));
    chk("reject_no_done", 64'(done_s), 64'(0));
    chk("reject_rdata", 64'(rdata_s), 64'(exp_rdata));
  endtask

  typedef struct {
    bit          inst;
    bit          c45;
    logic [1:0]  op;
    logic [4:0]  phy;
    logic [4:0]  rg;
    logic [15:0] wd;
    logic [15:0] rword;
    bit          exp_err;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t tbl[10];
  logic [15:0] last_rd[2];

  initial begin
    int n, rises_r, dn;
    bit prev_r;
    bit r_inst, r_c45, legal;
    logic [1:0] r_op;
    logic [4:0] r_phy, r_rg;
    logic [15:0] r_wd, r_rw, r_exp;

    tbl[0] = '{1'b0, 1'b0, 2'b01, 5'd5,  5'd3,  16'hA5C3, 16'h0000, 1'b0, 16'h0000};
    tbl[1] = '{1'b0, 1'b0, 2'b10, 5'd1,  5'd2,  16'h0000, 16'h1234, 1'b0, 16'h1234};
    tbl[2] = '{1'b0, 1'b1, 2'b00, 5'd3,  5'd1,  16'h0010, 16'h0000, 1'b0, 16'h1234};
    tbl[3] = '{1'b0, 1'b1, 2'b11, 5'd3,  5'd1,  16'h0000, 16'hBEEF, 1'b0, 16'hBEEF};
    tbl[4] = '{1'b1, 1'b0, 2'b10, 5'd7,  5'd9,  16'h0000, 16'h5A5A, 1'b0, 16'h5A5A};
    tbl[5] = '{1'b1, 1'b0, 2'b11, 5'd4,  5'd4,  16'hFFFF, 16'h0000, 1'b1, 16'h5A5A};
    tbl[6] = '{1'b1, 1'b1, 2'b01, 5'd2,  5'd2,  16'h1111, 16'h0000, 1'b1, 16'h5A5A};
    tbl[7] = '{1'b0, 1'b0, 2'b00, 5'd6,  5'd6,  16'h2222, 16'h0000, 1'b1, 16'hBEEF};
    tbl[8] = '{1'b0, 1'b1, 2'b10, 5'd8,  5'd30, 16'h0000, 16'h0F0F, 1'b0, 16'h0F0F};
    tbl[9] = '{1'b1, 1'b0, 2'b01, 5'd31, 5'd0,  16'h8001, 16'h0000, 1'b0, 16'h5A5A};

    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; sel = 1'b0; mdio_in = 1'b1;
    req_c45 = 1'b0; req_op = 2'b00; req_phy = 5'd0; req_reg = 5'd0; req_wdata = 16'h0;
    last_rd[0] = 16'h0; last_rd[1] = 16'h0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sel = (i == 1);
      #1;
      chk("rst_rdata", 64'(rdata_s), 64'(0));
      chk("rst_busy", 64'(busy_s), 64'(0));
      chk("rst_done_err", 64'({done_s, err_s}), 64'(0));
      chk("rst_mdc", 64'(mdc_s), 64'(0));
      chk("rst_mdio", 64'({mout_s, moe_s}), 64'(2'b10));
    end
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].exp_err)
        run_reject(tbl[i].inst, tbl[i].c45, tbl[i].op, tbl[i].phy, tbl[i].rg, tbl[i].wd,
                   tbl[i].exp_rdata);
      else
        run_frame(tbl[i].inst, tbl[i].c45, tbl[i].op, tbl[i].phy, tbl[i].rg, tbl[i].wd,
                  tbl[i].rword, tbl[i].exp_rdata, 1'b0, 1'b0);
      if (!tbl[i].exp_err && tbl[i].op[1]) last_rd[tbl[i].inst] = tbl[i].exp_rdata;
    end

    for (int k = 0; k < 16; k++) begin
      r_inst = 1'($urandom_range(0, 1));
      r_c45  = 1'($urandom_range(0, 1));
      r_op   = 2'($urandom_range(0, 3));
      r_phy  = 5'($urandom);
      r_rg   = 5'($urandom);
      r_wd   = 16'($urandom);
      r_rw   = 16'($urandom);
      legal  = r_c45 ? (r_inst == 1'b0) : (r_op == 2'b01 || r_op == 2'b10);
      if (legal) begin
        r_exp = r_op[1] ? r_rw : last_rd[r_inst];
        run_frame(r_inst, r_c45, r_op, r_phy, r_rg, r_wd, r_rw, r_exp, 1'b0, 1'b0);
        last_rd[r_inst] = r_exp;
      end else begin
        run_reject(r_inst, r_c45, r_op, r_phy, r_rg, r_wd, last_rd[r_inst]);
      end
    end

    // Second request mid-frame must be ignored; then start held high through the whole frame.
    run_frame(1'b0, 1'b0, 2'b01, 5'd9, 5'd4, 16'h1357, 16'h0, last_rd[0], 1'b0, 1'b1);
    run_frame(1'b0, 1'b0, 2'b01, 5'd17, 5'd12, 16'hC0DE, 16'h0, last_rd[0], 1'b1, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Reset during bit 40 of a write aborts the frame without done.
    sel = 1'b0;
    @(negedge clk);
    req_c45 = 1'b0; req_op = 2'b01; req_phy = 5'd5; req_reg = 5'd3; req_wdata = 16'hA5C3;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    rises_r = 0; prev_r = 1'b0;
    for (n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (mdc0 && !prev_r) rises_r++;
      prev_r = mdc0;
      if (rises_r == 40) break;
    end
    chk("reach_bit40", 64'(rises_r), 64'(40));
    reset = 1'b1;
    @(negedge clk);
    chk("abort_mdc", 64'(mdc0), 64'(0));
    chk("abort_oe", 64'(moe0), 64'(0));
    chk("abort_busy", 64'(busy0), 64'(0));
    chk("abort_done", 64'(done0), 64'(0));
    reset = 1'b0;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done0 || busy0) dn++;
    end
    chk("abort_quiet", 64'(dn), 64'(0));

    run_reject(1'b0, 1'b0, 2'b11, 5'd1, 5'd1, 16'h0, 16'h0);
    run_reject(1'b1, 1'b1, 2'b00, 5'd3, 5'd1, 16'h0010, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
